// File: rtl/riv_rdy_vld_source.sv
// Queued ready/valid source: words pushed on the load side are replayed to a sink
// as masked beats, optionally back-to-back or separated by programmable idle gaps.
module riv_rdy_vld_source #(
   parameter int MAX_WIDTH = 64,
   parameter int DEPTH     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load_valid,
   input  logic [MAX_WIDTH-1:0]     load_data,
   output logic                     load_ready,
   input  logic                     enable,
   input  logic [3:0]               gap_cycles,
   input  logic [MAX_WIDTH-1:0]     data_mask,
   output logic                     valid,
   input  logic                     ready,
   output logic [MAX_WIDTH-1:0]     data,
   output logic [31:0]              beat_count,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [MAX_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]        level_q, level_d;
   logic [3:0]           gap_q, gap_d;
   logic [MAX_WIDTH-1:0] data_q, data_d;
   logic [31:0]          beats_q;
   logic                 push_s, pop_s, hs_s, avail_s;

   // rst_n gates load_ready so nothing is accepted while reset is held
   assign load_ready = rst_n && (level_q != LW'(DEPTH));
   assign push_s     = load_valid && load_ready;
   assign hs_s       = (state_q == ST_DRIVE) && ready;
   assign avail_s    = enable && (level_q != {LW{1'b0}});

   assign valid      = (state_q == ST_DRIVE);
   assign data       = data_q;
   assign beat_count = beats_q;
   assign level      = level_q;

   // Beat sequencing: decides when the queue head moves into the output register
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      pop_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (avail_s) begin
               pop_s   = 1'b1;
               state_d = ST_DRIVE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            if (!ready) begin
               state_d = ST_DRIVE;
            end else if (gap_cycles != 4'd0) begin
               state_d = ST_GAP;
               gap_d   = gap_cycles;
            end else if (avail_s) begin
               pop_s   = 1'b1;
               state_d = ST_DRIVE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GAP: begin
            gap_d = gap_q - 4'd1;
            // The last gap cycle makes the idle decision itself, so the sink sees exactly G idle cycles
            if (gap_q > 4'd1) begin
               state_d = ST_GAP;
            end else if (avail_s) begin
               pop_s   = 1'b1;
               state_d = ST_DRIVE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gap_d   = 4'd0;
         end
      endcase
   end

   // Output word and occupancy next-state
   always_comb begin
      data_d  = data_q;
      level_d = level_q;
      if (pop_s) begin
         data_d = mem_q[rd_ptr_q] & data_mask;
      end else begin
         data_d = data_q;
      end
      case ({push_s, pop_s})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Queue storage; contents need no reset because the pointers define validity
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= load_data;
      end
   end

   // Control and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         level_q  <= {LW{1'b0}};
         gap_q    <= 4'd0;
         data_q   <= {MAX_WIDTH{1'b0}};
         beats_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         gap_q   <= gap_d;
         data_q  <= data_d;
         if (push_s) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (hs_s) begin
            beats_q <= beats_q + 32'd1;
         end
      end
   end

endmodule
